// File: rtl/sum_acc_pkg.sv
// Shared state encoding and default widths for the burst sum accumulator.
package sum_acc_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned LEN_W_DEF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/binary_adder.sv
// W-bit binary adder with carry in and carry out.
module binary_adder #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         Cin,
  output logic [W-1:0] SUM,
  output logic         Cout
);

  assign {Cout, SUM} = {1'b0, A} + {1'b0, B} + (W+1)'(Cin);

endmodule

// File: rtl/sum_accumulator.sv
// Burst accumulator: sums len operands through binary_adder, holds the total
// until the consumer handshakes, then returns to IDLE.
module sum_accumulator
  import sum_acc_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned LEN_W  = LEN_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LEN_W-1:0]        len,
  input  logic                    in_valid,
  input  logic [DATA_W-1:0]       in_data,
  output logic                    in_ready,
  output logic                    out_valid,
  output logic [DATA_W+LEN_W-1:0] out_sum,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    err
);

  state_t              r_state;
  state_t              w_state_next;
  logic                w_err_next;
  logic                w_load;
  logic                w_accept;
  logic                r_in_ready;
  logic                r_out_valid;
  logic                r_busy;
  logic                r_err;
  logic [DATA_W-1:0]   r_acc_lo;
  logic [LEN_W-1:0]    r_acc_hi;
  logic [LEN_W-1:0]    r_remain;
  logic [DATA_W-1:0]   w_sum;
  logic                w_cout;

  // r_in_ready mirrors state==ACC, so the accept strobe never looks at outputs combinationally
  assign w_accept = in_valid & r_in_ready;

  binary_adder #(
    .W (DATA_W)
  ) u_adder (
    .A    (r_acc_lo),
    .B    (in_data),
    .Cin  (1'b0),
    .SUM  (w_sum),
    .Cout (w_cout)
  );

  always_comb begin
    w_state_next = r_state;
    w_err_next   = 1'b0;
    w_load       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (len != '0) begin
            w_state_next = ST_ACC;
            w_load       = 1'b1;
          end else begin
            w_err_next = 1'b1;
          end
        end
      end
      ST_ACC: begin
        if (w_accept && (r_remain == LEN_W'(1))) begin
          w_state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State plus state-decoded flags, registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_in_ready  <= (w_state_next == ST_ACC);
      r_out_valid <= (w_state_next == ST_HOLD);
      r_busy      <= (w_state_next != ST_IDLE);
      r_err       <= w_err_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc_lo <= '0;
      r_acc_hi <= '0;
      r_remain <= '0;
    end else if (w_load) begin
      r_acc_lo <= '0;
      r_acc_hi <= '0;
      r_remain <= len;
    end else if (w_accept) begin
      r_acc_lo <= w_sum;
      r_acc_hi <= r_acc_hi + LEN_W'(w_cout);
      r_remain <= r_remain - LEN_W'(1);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign err       = r_err;
  assign out_sum   = {r_acc_hi, r_acc_lo};

endmodule

// File: tb/tb_sum_accumulator.sv
// Self-checking bench for sum_accumulator: directed and random bursts against a sum-of-operands model.
module tb_sum_accumulator;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  len;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [11:0] out_sum;
  logic        out_ready;
  logic        busy;
  logic        err;

  int          n_total;
  int          n_pass;
  logic [7:0]  ops [$];

  sum_accumulator #(
    .DATA_W (8),
    .LEN_W  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_sum   (out_sum),
    .out_ready (out_ready),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Issues start with len = ops.size(), feeds ops with random gaps, then holds the
  // result for hold_wait cycles (optionally pulsing start) before the handshake.
  task automatic run_burst(input string tag, input int gap_pct, input int hold_wait, input bit pulse);
    int exp_sum;
    int k;
    int guard;
    exp_sum = 0;
    foreach (ops[i]) exp_sum += int'(ops[i]);
    chk({tag, "_idle_in_ready"}, 32'(in_ready), 32'd0);
    start = 1'b1;
    len   = 4'(ops.size());
    tick();
    start = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_acc_in_ready"}, 32'(in_ready), 32'd1);
    k = 0;
    guard = 0;
    while (k < ops.size() && guard < 2000) begin
      if (int'($urandom_range(99)) < gap_pct) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = ops[k];
        k++;
      end
      tick();
      guard++;
      if (k < ops.size()) chk({tag, "_no_early_out"}, 32'(out_valid), 32'd0);
    end
    chk({tag, "_feed_bound"}, 32'(k), 32'(ops.size()));
    in_valid = 1'b0;
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_out_sum"}, 32'(out_sum), 32'(exp_sum));
    chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
    for (int i = 0; i < hold_wait; i++) begin
      out_ready = 1'b0;
      if (pulse && i == 1) begin
        start = 1'b1;
        len   = 4'd3;
      end
      tick();
      start = 1'b0;
      chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_sum"}, 32'(out_sum), 32'(exp_sum));
      chk({tag, "_hold_err"}, 32'(err), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_done_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_done_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done_in_ready"}, 32'(in_ready), 32'd0);
  endtask

  initial begin
    n_total   = 0;
    n_pass    = 0;
    rst       = 1'b1;
    start     = 1'b0;
    len       = 4'd0;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    out_ready = 1'b0;

    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    tick();
    rst = 1'b0;

    // First start right after reset release; 1 + 1
    ops = '{8'h01, 8'h01};
    run_burst("b2_ones", 0, 0, 1'b0);

    ops = '{8'hFF, 8'h01};
    run_burst("b2_carry", 0, 1, 1'b0);

    ops = {};
    for (int i = 0; i < 15; i++) ops.push_back(8'hFF);
    run_burst("b15_ff", 40, 0, 1'b0);

    // Zero-length start is rejected with a single err pulse
    start = 1'b1;
    len   = 4'd0;
    tick();
    start = 1'b0;
    chk("len0_err", 32'(err), 32'd1);
    chk("len0_busy", 32'(busy), 32'd0);
    chk("len0_out_valid", 32'(out_valid), 32'd0);
    tick();
    chk("len0_err_clear", 32'(err), 32'd0);
    chk("len0_busy2", 32'(busy), 32'd0);
    chk("len0_out_valid2", 32'(out_valid), 32'd0);

    ops = '{8'h12, 8'h34, 8'h56};
    run_burst("hold_wait", 0, 5, 1'b1);

    // Reset mid-burst after 3 of 5 operands
    start = 1'b1;
    len   = 4'd5;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h40;
      tick();
    end
    in_valid = 1'b0;
    chk("mid_acc_sum", 32'(out_sum), 32'h0C0);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_out_sum", 32'(out_sum), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    tick();
    rst = 1'b0;
    ops = '{8'h55};
    run_burst("after_rst", 0, 0, 1'b0);

    for (int b = 0; b < 6; b++) begin
      ops = {};
      for (int i = 0; i < int'($urandom_range(15, 1)); i++) ops.push_back(8'($urandom));
      run_burst($sformatf("rand%0d", b), 30, int'($urandom_range(3)), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 SHALL have parameter DATA_W, default 8, operand width; fixed to the binary_adder width.
REQ-002 SHALL have parameter LEN_W, default 4, burst-length field width (bursts of 1..15 operands).
REQ-003 SHALL have a single clock and a reset that is asynchronous and active-high: clk input, 1 bit, rising-edge clock.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 start  input  1  request a new burst; sampled only in IDLE.
REQ-006 len  input  LEN_W  operand count for the burst, sampled with start.
REQ-007 in_valid  input  1  in_data valid.
REQ-008 in_data  input  DATA_W  operand.
REQ-009 in_ready  output  1  block accepts an operand this cycle.
REQ-010 out_valid  output  1  out_sum valid.
REQ-011 out_sum  output  DATA_W+LEN_W  burst total (12 bits at defaults).
REQ-012 out_ready  input  1  consumer accepts out_sum.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 err  output  1  one-cycle pulse flagging a rejected start.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, ACC and HOLD.
REQ-016 IDLE, start=1, len!=0 -> ACC next cycle; acc_lo cleared to 0, acc_hi cleared to 0, remain loaded with len.
REQ-017 IDLE, start=1, len=0 -> stay IDLE; err=1 for exactly the next cycle; no other state changes.
REQ-018 in_ready SHALL be 1 only in ACC; in_data is accepted on any cycle with in_valid & in_ready.
REQ-019 Each accept: acc_lo <= SUM of binary_adder(A=acc_lo, B=in_data, Cin=0); acc_hi <= acc_hi + Cout; remain <= remain - 1.
REQ-020 An accept with remain=1 SHALL move the FSM to HOLD on the next cycle.
REQ-021 in_valid=0 in ACC SHALL stall; no state change for any number of idle cycles.
REQ-022 HOLD: out_valid=1, out_sum={acc_hi, acc_lo}, stable until the handshake; out_valid & out_ready -> IDLE next cycle.
REQ-023 Latency: out_valid SHALL rise on the cycle after the last operand is accepted.
REQ-024 Maximum total is 15*255=3825; acc_hi SHALL never wrap at the defaults; no overflow flag is required.
REQ-025 start while busy SHALL be ignored, raise no err and cause no state change.
REQ-026 A new burst may start in the cycle after a HOLD handshake, giving a minimum of one IDLE cycle between bursts.
REQ-027 out_valid, in_ready and err SHALL be registered or derived only from state; no combinational path from in_valid or out_ready to any output.

Reset
REQ-028 rst=1 SHALL immediately force state=IDLE and acc_lo, acc_hi, remain=0, regardless of clk.
REQ-029 While rst=1: out_valid=0, in_ready=0, busy=0, err=0 and out_sum=0.
REQ-030 Reset during ACC or HOLD SHALL abandon the burst; the partial sum is never presented.
REQ-031 The first start SHALL be honoured on the first rising clk edge after rst deasserts.

Structure
REQ-032 State encodings (IDLE/ACC/HOLD) and default widths SHALL live in shared package sum_acc_pkg.
REQ-033 The 8-bit addition SHALL use one instance of the existing binary_adder (A, B, Cin, SUM, Cout) as its only sub-module; no behavioural + on acc_lo.
REQ-034 acc_hi increment and remain decrement SHALL be plain counters in this module.

Verification
REQ-035 start, len=2; operands 0x01, 0x01 -> out_valid on the cycle after the 2nd accept, out_sum=0x002.
REQ-036 len=2; operands 0xFF, 0x01 -> out_sum=0x100 (carry into acc_hi).
REQ-037 len=15; all operands 0xFF with random in_valid gaps -> out_sum=0xEF1; in_ready low outside ACC.
REQ-038 start with len=0 -> err high exactly one cycle, busy stays 0, no out_valid.
REQ-039 HOLD with out_ready held low 5 cycles, start pulsed during HOLD -> out_sum stable, start ignored; handshake on the 6th cycle -> IDLE.
REQ-040 rst asserted mid-ACC after 3 of 5 operands -> outputs 0 at once; a new burst of len=1, operand 0x55 -> out_sum=0x055.
